// File: rtl/ofdm_cp_remover_if.sv
// Sample-stream bundle around the CP remover: i_* side from the Schmidl-Cox block, o_* side to the FFT.
interface ofdm_cp_remover_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] i_tdata;
  logic             i_tlast;
  logic             i_tvalid;
  logic             i_tready;
  logic [WIDTH-1:0] o_tdata;
  logic             o_tlast;
  logic             o_tvalid;
  logic             o_tready;

  modport slave (
    input  i_tdata, i_tlast, i_tvalid,
    output i_tready,
    output o_tdata, o_tlast, o_tvalid,
    input  o_tready
  );

  modport master (
    output i_tdata, i_tlast, i_tvalid,
    input  i_tready,
    input  o_tdata, o_tlast, o_tvalid,
    output o_tready
  );
endinterface

// File: rtl/ofdm_cp_remover.sv
// Strips the cyclic prefix from each OFDM symbol; zero-latency pass-through, input stalls only while body samples wait on o_tready.
// Define OFDM_CP_REMOVER_TIMING_ADVANCE_EN to start the FFT window `advance` samples early inside the CP.
module ofdm_cp_remover #(
  parameter int BASE         = 0,
  parameter int WIDTH        = 32,
  parameter int MAX_LEN_LOG2 = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   set_stb,
  input  logic [7:0]             set_addr,
  input  logic [31:0]            set_data,
  ofdm_cp_remover_if.slave       bus,
  output logic                   short_err,
  output logic                   long_err
);

  localparam int L = MAX_LEN_LOG2;
  typedef logic [L-1:0] len_t;

  localparam len_t       FFT_DEF = len_t'(64);
  localparam len_t       CP_DEF  = len_t'(16);
  localparam len_t       ONE     = len_t'(1);
  localparam logic [7:0] A_FFT   = 8'(BASE);
  localparam logic [7:0] A_CP    = 8'(BASE + 1);

`ifdef OFDM_CP_REMOVER_TIMING_ADVANCE_EN
  typedef enum logic [1:0] {S_CP, S_DATA, S_DRAIN, S_TAIL} state_t;
`else
  typedef enum logic [1:0] {S_CP, S_DATA, S_DRAIN} state_t;
`endif

  state_t r_state;
  state_t w_state_nxt;
  len_t   r_cnt;
  len_t   w_cnt_nxt;
  len_t   r_fft_set;
  len_t   r_cp_set;
  len_t   r_fft_len;
  len_t   r_cp_len;
  logic   r_short_err;
  logic   r_long_err;
  logic   w_short_nxt;
  logic   w_long_nxt;

  len_t   w_set_val;
  len_t   w_fft_fresh;
  len_t   w_cp_fresh;
  len_t   w_fft_eff;
  len_t   w_cp_eff;
  len_t   w_adv_eff;
  len_t   w_disc;
  len_t   w_fft_m1;
  logic   w_start;
  logic   w_data_phase;
  logic   w_xfer;
  logic   w_unused_set_data;

  assign w_set_val         = set_data[L-1:0];
  assign w_unused_set_data = ^set_data[31:L];

  // Settings as they stand this cycle, including a write landing right now.
  assign w_fft_fresh = (set_stb && (set_addr == A_FFT)) ? w_set_val : r_fft_set;
  assign w_cp_fresh  = (set_stb && (set_addr == A_CP))  ? w_set_val : r_cp_set;

  // At symbol start the fresh settings drive this cycle's decisions and get latched.
  assign w_start   = (r_state == S_CP) && (r_cnt == '0);
  assign w_fft_eff = w_start ? ((w_fft_fresh == '0) ? ONE : w_fft_fresh) : r_fft_len;
  assign w_cp_eff  = w_start ? w_cp_fresh : r_cp_len;

`ifdef OFDM_CP_REMOVER_TIMING_ADVANCE_EN
  localparam logic [7:0] A_ADV = 8'(BASE + 2);
  len_t r_adv_set;
  len_t r_adv_len;
  len_t w_adv_fresh;

  assign w_adv_fresh = (set_stb && (set_addr == A_ADV)) ? w_set_val : r_adv_set;
  assign w_adv_eff   = w_start ? ((w_adv_fresh > w_cp_fresh) ? w_cp_fresh : w_adv_fresh)
                               : r_adv_len;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_adv_set <= '0;
      r_adv_len <= '0;
    end else begin
      r_adv_set <= w_adv_fresh;
      if (w_start) begin
        r_adv_len <= w_adv_eff;
      end
    end
  end
`else
  assign w_adv_eff = '0;
`endif

  assign w_disc   = w_cp_eff - w_adv_eff;
  assign w_fft_m1 = w_fft_eff - ONE;

  // A zero-length prefix puts S_CP straight into the body phase without a wasted cycle.
  assign w_data_phase = (r_state == S_DATA) || ((r_state == S_CP) && (w_disc == '0));

  assign bus.o_tdata  = WIDTH'(bus.i_tdata);
  assign bus.o_tvalid = w_data_phase & bus.i_tvalid;
  assign bus.o_tlast  = w_data_phase & ((r_cnt == w_fft_m1) | bus.i_tlast);
  assign bus.i_tready = w_data_phase ? bus.o_tready : 1'b1;
  assign w_xfer       = bus.i_tvalid & bus.i_tready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fft_set <= FFT_DEF;
      r_cp_set  <= CP_DEF;
      r_fft_len <= FFT_DEF;
      r_cp_len  <= CP_DEF;
    end else begin
      r_fft_set <= w_fft_fresh;
      r_cp_set  <= w_cp_fresh;
      if (w_start) begin
        r_fft_len <= w_fft_eff;
        r_cp_len  <= w_cp_eff;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_short_nxt = 1'b0;
    w_long_nxt  = 1'b0;
    if (w_data_phase) begin
      if (w_xfer) begin
        w_cnt_nxt = '0;
        if (r_cnt == w_fft_m1) begin
`ifdef OFDM_CP_REMOVER_TIMING_ADVANCE_EN
          if (w_adv_eff != '0) begin
            w_short_nxt = bus.i_tlast;
            w_state_nxt = bus.i_tlast ? S_CP : S_TAIL;
          end else
`endif
          if (bus.i_tlast) begin
            w_state_nxt = S_CP;
          end else begin
            w_long_nxt  = 1'b1;
            w_state_nxt = S_DRAIN;
          end
        end else if (bus.i_tlast) begin
          w_short_nxt = 1'b1;
          w_state_nxt = S_CP;
        end else begin
          w_cnt_nxt   = r_cnt + ONE;
          w_state_nxt = S_DATA;
        end
      end
    end else begin
      case (r_state)
        S_CP: begin
          if (w_xfer) begin
            if (bus.i_tlast) begin
              w_short_nxt = 1'b1;
              w_cnt_nxt   = '0;
            end else if (r_cnt == (w_disc - ONE)) begin
              w_state_nxt = S_DATA;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = r_cnt + ONE;
            end
          end
        end
`ifdef OFDM_CP_REMOVER_TIMING_ADVANCE_EN
        S_TAIL: begin
          if (w_xfer) begin
            w_cnt_nxt = '0;
            if (r_cnt == (w_adv_eff - ONE)) begin
              w_long_nxt  = ~bus.i_tlast;
              w_state_nxt = bus.i_tlast ? S_CP : S_DRAIN;
            end else if (bus.i_tlast) begin
              w_short_nxt = 1'b1;
              w_state_nxt = S_CP;
            end else begin
              w_cnt_nxt = r_cnt + ONE;
            end
          end
        end
`endif
        S_DRAIN: begin
          if (w_xfer && bus.i_tlast) begin
            w_state_nxt = S_CP;
            w_cnt_nxt   = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Soft clear also swallows any transfer completing in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_state     <= S_CP;
      r_cnt       <= '0;
      r_short_err <= 1'b0;
      r_long_err  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_short_err <= w_short_nxt;
      r_long_err  <= w_long_nxt;
    end
  end

  assign short_err = r_short_err;
  assign long_err  = r_long_err;

endmodule

// File: doc/ofdm_cp_remover.md
Name: ofdm_cp_remover

Overview:
- Sits directly downstream of the Schmidl-Cox timing/CFO block.
- Consumes its framed, CFO-corrected sample stream. Each input packet is one OFDM symbol (CP + body), with tlast on the last sample.
- Strips the cyclic prefix and emits exactly FFT_LEN samples per symbol, with tlast on the last one, ready for the FFT.
- Flags malformed (short or long) symbols and resynchronises on the next input tlast.

Parameters:
- BASE, 0, settings-bus base address.
- WIDTH, 32, sample width ({I[15:0],Q[15:0]} at default).
- MAX_LEN_LOG2, 10, width of the length counters and settings fields.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- clear  in  1  synchronous soft clear; resets FSM and counters, keeps settings.
- set_stb  in  1  settings strobe.
- set_addr  in  8  settings address.
- set_data  in  32  settings data.
- i_tdata  in  WIDTH  input samples.
- i_tlast  in  1  end of input symbol.
- i_tvalid  in  1  input valid.
- i_tready  out  1  input ready.
- o_tdata  out  WIDTH  output samples (CP removed).
- o_tlast  out  1  last sample of FFT window.
- o_tvalid  out  1  output valid.
- o_tready  in  1  output ready.
- short_err  out  1  one-cycle pulse: input tlast arrived before FFT_LEN body samples were emitted.
- long_err  out  1  one-cycle pulse: body complete but input tlast not yet seen.

Behaviour:
- One clock, clk. reset is synchronous, active-high.
- Settings registers (reset values in brackets):
  - BASE+0 fft_len[MAX_LEN_LOG2-1:0] [64].
  - BASE+1 cp_len [16].
  - Written any time. Copied into active registers only at symbol start (FSM in S_CP with sample count 0, or on entering S_CP); a mid-symbol write takes effect from the next symbol.
- Clamping at latch:
  - fft_len=0 is treated as 1.
  - cp_len is used as written; 0 is legal.
- Datapath is pass-through, zero cycles latency: o_tdata = i_tdata.
- Reset values: FSM = S_CP, counters = 0, short_err = long_err = 0.
- FSM with a single counter cnt:
  - S_CP:
    - i_tready = 1, o_tvalid = 0. Each accepted sample increments cnt.
    - When cnt reaches cp_len-1 on an accepted sample (or at once if cp_len = 0), go to S_DATA with cnt = 0.
    - Accepted i_tlast in S_CP: pulse short_err, stay in S_CP, cnt = 0, relatch settings.
  - S_DATA:
    - o_tvalid = i_tvalid, i_tready = o_tready. A transfer occurs when i_tvalid & o_tready.
    - o_tlast = (cnt == fft_len-1) | i_tlast.
    - Transfer with cnt == fft_len-1 and i_tlast: go to S_CP (normal case).
    - Transfer with cnt == fft_len-1 and no i_tlast: pulse long_err, go to S_DRAIN.
    - Transfer with i_tlast and cnt < fft_len-1: pulse short_err, go to S_CP. The truncated window is terminated by the forced o_tlast.
  - S_TAIL (only with the optional feature): i_tready = 1, o_tvalid = 0. Discards `advance` samples, then behaves as the end of S_DATA.
  - S_DRAIN: i_tready = 1, o_tvalid = 0. Discards samples until accepted i_tlast, then goes to S_CP.
- short_err and long_err are registered and asserted the cycle after the triggering transfer.
- Simultaneous clear with a transfer: clear wins; the transfer is accepted but discarded and the FSM returns to S_CP.
- Simultaneous settings write with symbol start: the new value is used.
- Reset mid-symbol: settings return to defaults and the FSM restarts in S_CP. The upstream is expected to be reset or cleared together with this block.

Optional Feature:
- Macro: OFDM_CP_REMOVER_TIMING_ADVANCE_EN.
- With the macro:
  - Adds setting BASE+2 advance [0]. It is clamped to cp_len at latch time.
  - S_CP discards cp_len-advance samples.
  - S_DATA emits fft_len samples with o_tlast at cnt == fft_len-1, even without input tlast.
  - S_TAIL then discards `advance` samples. An accepted i_tlast on the last of them is the normal case.
  - i_tlast before the tail completes pulses short_err; a missing i_tlast after the tail pulses long_err and enters S_DRAIN.
  - This positions the FFT window earlier inside the CP for multipath margin.
- Without the macro: BASE+2 writes are ignored, S_TAIL does not exist, and behaviour is identical to advance = 0.

Test Plan:
- Defaults (fft 64, cp 16), three 80-sample symbols with samples = index, o_tready = 1 -> 3 output packets of 64 samples; first packet = 16..79, o_tlast on 79; no error pulses.
- Same stimulus, o_tready toggling 1-of-3 cycles -> identical output data and order; no loss; i_tready low only in S_DATA when o_tready is low.
- 50-sample symbol, then an 80-sample symbol -> 34 samples out with o_tlast on the 34th; short_err pulses once; next symbol outputs 64 samples correctly.
- 90-sample symbol -> 64 out; long_err pulses once; 10 samples drained; next 80-sample symbol is normal.
- Write cp_len = 8 halfway through a symbol, then send 80 then 72 samples -> first symbol still strips 16; second strips 8 and outputs 64.
- With the macro, advance = 4, 80-sample symbols -> output = samples 12..75; no errors. advance = 20 is clamped to 16 -> output 0..63.
